// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 15;
  localparam logic [ADDR_W-1:0] REG_PC = 4'd15;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {SRC_PIPE, SRC_MUL, SRC_FPU, SRC_NONE} src_t;

  // One-hot pending mask of a buffered entry; R15 never reaches a buffer.
  function automatic logic [NUM_REGS-1:0] busy_decode(input wb_entry_t e);
    logic [2**ADDR_W-1:0] d;
    d = '0;
    d[e.addr] = e.valid;
    return d[NUM_REGS-1:0];
  endfunction

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding buffer for a late result producer, with starvation
// counter, ready generation and R15 drop detection.
module wb_hold_buf
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              bypass,
  input  logic              grant,
  output logic              ready,
  output wb_entry_t         entry,
  output logic              starved,
  output logic              take,
  output logic              err_r15
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt;
  logic          accept;
  logic          drop;

  // Ready only when empty, so a draining entry cannot be replaced in the same cycle.
  assign ready   = !entry.valid && !rst;
  assign accept  = in_valid && ready;
  assign drop    = accept && (in_addr == REG_PC);
  assign take    = accept && !drop && !bypass;
  assign starved = entry.valid && (cnt >= LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry   <= '0;
      cnt     <= '0;
      err_r15 <= 1'b0;
    end else begin
      err_r15 <= drop;
      if (grant) begin
        entry.valid <= 1'b0;
        cnt         <= '0;
      end else if (take) begin
        entry <= '{valid: 1'b1, addr: in_addr, data: in_data};
        cnt   <= '0;
      end else if (entry.valid && cnt != LIMIT) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Write-port arbiter merging pipeline writeback, multiplier and FPU results.
// Optional zero-latency Mul/Fpu bypass when WBARB_BYPASS_EN is defined.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                PipeValid,
  input  logic [ADDR_W-1:0]   PipeA3,
  input  logic [DATA_W-1:0]   PipeWD,
  input  logic                MulValid,
  output logic                MulReady,
  input  logic [ADDR_W-1:0]   MulA3,
  input  logic [DATA_W-1:0]   MulWD,
  input  logic                FpuValid,
  output logic                FpuReady,
  input  logic [ADDR_W-1:0]   FpuA3,
  input  logic [DATA_W-1:0]   FpuWD,
  output logic                WE3,
  output logic [ADDR_W-1:0]   A3,
  output logic [DATA_W-1:0]   WD3,
  output logic                StallReq,
  output logic [NUM_REGS-1:0] Busy,
  output logic                ErrR15
);

  wb_entry_t         mul_e, fpu_e;
  logic              mul_starved, fpu_starved;
  logic              mul_take, fpu_take;
  logic              mul_err, fpu_err;
  logic              mul_byp, fpu_byp;
  logic              mul_grant, fpu_grant;
  logic              rr_fpu;      // round-robin pointer: 0 = Mul next
  logic              fpu_older;   // age flag: 1 = Fpu entry accepted first
  logic              rr_toggle;
  src_t              src;
  logic              gnt_we;
  logic [ADDR_W-1:0] gnt_addr, last_a3;
  logic [DATA_W-1:0] gnt_data, last_wd;

  wb_hold_buf #(.STARVE_LIMIT(STARVE_LIMIT)) u_mul_buf (
    .clk(CLK), .rst(RESET), .in_valid(MulValid), .in_addr(MulA3), .in_data(MulWD),
    .bypass(mul_byp), .grant(mul_grant), .ready(MulReady), .entry(mul_e),
    .starved(mul_starved), .take(mul_take), .err_r15(mul_err)
  );

  wb_hold_buf #(.STARVE_LIMIT(STARVE_LIMIT)) u_fpu_buf (
    .clk(CLK), .rst(RESET), .in_valid(FpuValid), .in_addr(FpuA3), .in_data(FpuWD),
    .bypass(fpu_byp), .grant(fpu_grant), .ready(FpuReady), .entry(fpu_e),
    .starved(fpu_starved), .take(fpu_take), .err_r15(fpu_err)
  );

  assign StallReq = mul_starved || fpu_starved;
  assign Busy     = busy_decode(mul_e) | busy_decode(fpu_e);
  assign ErrR15   = mul_err || fpu_err;

  always_comb begin
    src       = SRC_NONE;
    rr_toggle = 1'b0;
    mul_byp   = 1'b0;
    fpu_byp   = 1'b0;
    if (StallReq) begin
      src = mul_starved ? SRC_MUL : SRC_FPU;
    end else if (PipeValid) begin
      src = SRC_PIPE;
    end else if (mul_e.valid && fpu_e.valid) begin
      rr_toggle = 1'b1;
      // Same destination: oldest write must land last-but-one, so age wins.
      if (mul_e.addr == fpu_e.addr) src = fpu_older ? SRC_FPU : SRC_MUL;
      else                          src = rr_fpu ? SRC_FPU : SRC_MUL;
    end else if (mul_e.valid) begin
      src = SRC_MUL;
    end else if (fpu_e.valid) begin
      src = SRC_FPU;
    end
`ifdef WBARB_BYPASS_EN
    else if (MulValid && MulReady && MulA3 != REG_PC) begin
      src     = SRC_MUL;
      mul_byp = 1'b1;
    end else if (FpuValid && FpuReady && FpuA3 != REG_PC) begin
      src     = SRC_FPU;
      fpu_byp = 1'b1;
    end
`endif
  end

  always_comb begin
    gnt_we   = 1'b0;
    gnt_addr = last_a3;
    gnt_data = last_wd;
    case (src)
      SRC_PIPE: begin
        if (PipeA3 != REG_PC) begin
          gnt_we   = 1'b1;
          gnt_addr = PipeA3;
          gnt_data = PipeWD;
        end
      end
      SRC_MUL: begin
        gnt_we   = 1'b1;
        gnt_addr = mul_byp ? MulA3 : mul_e.addr;
        gnt_data = mul_byp ? MulWD : mul_e.data;
      end
      SRC_FPU: begin
        gnt_we   = 1'b1;
        gnt_addr = fpu_byp ? FpuA3 : fpu_e.addr;
        gnt_data = fpu_byp ? FpuWD : fpu_e.data;
      end
      default: ;
    endcase
  end

  assign mul_grant = (src == SRC_MUL) && !mul_byp;
  assign fpu_grant = (src == SRC_FPU) && !fpu_byp;
  assign WE3       = gnt_we && !RESET;
  assign A3        = WE3 ? gnt_addr : last_a3;
  assign WD3       = WE3 ? gnt_data : last_wd;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rr_fpu    <= 1'b0;
      fpu_older <= 1'b0;
      last_a3   <= '0;
      last_wd   <= '0;
    end else begin
      rr_fpu <= rr_fpu ^ rr_toggle;
      if (mul_take && !fpu_take) fpu_older <= fpu_e.valid;
      else if (fpu_take)         fpu_older <= 1'b0;
      if (WE3) begin
        last_a3 <= A3;
        last_wd <= WD3;
      end
    end
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer-side front end of the register file write port (WE3/A3/WD3, written on negedge CLK).
- Merges three result producers into the single write port:
  - main pipeline writeback (fixed timing, cannot be back-pressured);
  - multi-cycle multiplier;
  - floating-point unit.
- Buffers late results, arbitrates, and exports a pending-destination mask so the hazard unit can stall dependent reads.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 4, register address width (R0–R14 writable, R15 = PC never written)
- STARVE_LIMIT, 4, consecutive cycles a buffered result may lose to the pipeline before a stall is forced

Ports:
- CLK  in  1  system clock; state updates on posedge
- RESET  in  1  asynchronous, active-high reset
- PipeValid  in  1  pipeline writeback write request this cycle
- PipeA3  in  ADDR_W  pipeline destination register
- PipeWD  in  DATA_W  pipeline write data
- MulValid  in  1  multiplier result valid
- MulReady  out  1  Mul holding buffer can accept
- MulA3  in  ADDR_W  multiplier destination register
- MulWD  in  DATA_W  multiplier result
- FpuValid  in  1  FPU result valid
- FpuReady  out  1  FPU holding buffer can accept
- FpuA3  in  ADDR_W  FPU destination register
- FpuWD  in  DATA_W  FPU result
- WE3  out  1  register file write enable
- A3  out  ADDR_W  register file write address
- WD3  out  DATA_W  register file write data
- StallReq  out  1  forces hazard unit to hold the pipeline (PipeValid deferred)
- Busy  out  15  bit i = a buffered result targeting Ri is pending
- ErrR15  out  1  one-cycle pulse when a Mul/Fpu result targeting R15 is dropped

Behaviour:
- Holding buffers:
  - One 1-entry holding buffer each for Mul and Fpu: valid bit, addr, data.
  - Ready = buffer empty; a result is accepted at posedge when Valid & Ready.
  - A buffer that drains in a cycle does not accept in that same cycle; Ready rises the following cycle.
- Write-port grant (combinational outputs, evaluated each cycle):
  1. If StallReq=1: grant the starved buffer. The hazard unit guarantees PipeValid=0 in this cycle.
  2. Else if PipeValid=1: grant the pipeline with zero latency (PipeA3/PipeWD drive A3/WD3).
  3. Else if one buffer is full: grant it.
  4. Else if both are full: grant the round-robin pointer's buffer, then toggle the pointer.
- Granted buffer clears at the next posedge.
- Minimum latency, source accept to WE3: 1 cycle.
- R15 handling:
  - WE3 is never asserted with A3=15.
  - Pipe writes to 15 are suppressed silently.
  - Mul/Fpu results to 15 are accepted, discarded without buffering, and pulse ErrR15 for one cycle.
- No grant: WE3=0; A3/WD3 hold their last granted values.
- Starvation:
  - Per-buffer counter increments each cycle the buffer is full and not granted; it clears when granted.
  - StallReq = any counter ≥ STARVE_LIMIT.
  - If both buffers are starved, the Mul buffer is served first.
- Busy:
  - OR of the one-hot decode of each full buffer's addr.
  - Set the cycle after accept; cleared the cycle after drain.
  - The hazard unit must not issue a pipeline writer to a Busy register, so there are no WAW conflicts.
- Same destination held in both buffers: older-first by accept order, tracked with a 1-bit age flag; this overrides round-robin.
- Simultaneous accept on both sources in one cycle: both are buffered; Mul is treated as older.
- Reset (async):
  - Buffers empty, counters 0, pointer = Mul, age flag 0.
  - WE3=0, A3=0, WD3=0, StallReq=0, Busy=0, ErrR15=0.
  - MulReady=FpuReady=0 while RESET is high.
- Reset mid-operation: buffered results are lost; producers must restart.

Optional Feature:
- Macro: WBARB_BYPASS_EN.
- Defined: when a source's buffer is empty, PipeValid=0, StallReq=0, and no other buffer is full, a valid Mul or Fpu result writes directly on WE3 in the accept cycle (0 latency) and is not buffered. Mul wins if both bypass in the same cycle; the Fpu result is buffered instead.
- Undefined: every Mul/Fpu result passes through its buffer (latency ≥ 1).

Decomposition:
- Shared package wb_pkg:
  - constants DATA_W, ADDR_W, REG_PC=4'd15;
  - struct wb_entry_t {valid, addr, data};
  - enum src_t {SRC_PIPE, SRC_MUL, SRC_FPU, SRC_NONE}.
- One natural sub-module: wb_hold_buf, instantiated twice. It holds the entry, starvation counter, ready, and R15 drop logic; the top level holds grant, round-robin, and age logic.

Test Plan:
- Mul result R3=0x0000_00AA with PipeValid=0 → WE3=1, A3=3, WD3=0xAA one cycle later; Busy[3] high for exactly 1 cycle.
- Mul(R4) and Fpu(R5) valid in the same cycle, pipe idle → R4 written at cycle+1, R5 at cycle+2; FpuReady low until the cycle after R5 drains.
- Mul result R6 with PipeValid held 1 to R1 → WE3 carries R1 for 4 cycles, then StallReq=1 with A3=6 on cycle 5; counter clears.
- FpuA3=15, FpuWD=0xDEAD → ErrR15 pulses 1 cycle; WE3 never asserted with A3=15; FpuReady stays 1.
- RESET asserted while both buffers are full → immediately WE3=0, Busy=0, Ready=0; after release Ready=1 and no stale write occurs.
- Bypass (WBARB_BYPASS_EN defined): Mul R2=0x1234, all idle → WE3=1, A3=2 in the accept cycle; Busy[2] never set.
